// File: rtl/maple_bus_pkg.sv
// Shared types and constants for the Maple Bus host transaction sequencer.
package maple_bus_pkg;

  localparam int MAPLE_TIMEOUT_W = 24;
  localparam int MAPLE_TURN_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_ARM,
    ST_TX_ACTIVE,
    ST_TURN,
    ST_RX_WAIT,
    ST_RX_ACTIVE,
    ST_DONE
  } maple_state_e;

  localparam logic [2:0] MAPLE_ST_OK         = 3'd0;
  localparam logic [2:0] MAPLE_ST_TX_TIMEOUT = 3'd1;
  localparam logic [2:0] MAPLE_ST_RX_TIMEOUT = 3'd2;
  localparam logic [2:0] MAPLE_ST_RX_ERR     = 3'd3;
  localparam logic [2:0] MAPLE_ST_ABORT      = 3'd4;
  localparam logic [2:0] MAPLE_ST_NO_PKT     = 3'd5;

endpackage

// File: rtl/maple_seq_timer.sv
// Phase timer: clearable up-counter that saturates at its limit and flags the
// last cycle of a limit-long window. A zero limit means "never expire".
module maple_seq_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         hit
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] count;
  logic [W-1:0] sat;

  // With no limit the counter parks at all-ones instead of wrapping.
  assign sat = (limit == '0) ? '1 : limit;
  assign hit = (limit != '0) && (count == limit - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != sat) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/maple_bus_sequencer.sv
// Maple Bus host exchange sequencer: TX enable, turnaround, bounded RX window.
// Optional sticky completion interrupt when MAPLE_SEQ_IRQ_EN is defined.
module maple_bus_sequencer
  import maple_bus_pkg::*;
#(
  parameter int TIMEOUT_W = MAPLE_TIMEOUT_W,
  parameter int TURN_W    = MAPLE_TURN_W
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic [TURN_W-1:0]    cfg_turnaround,
  input  logic                 tx_pkt_avail,
  input  logic                 transmitting,
  input  logic                 receiving,
  input  logic                 rx_tvalid,
  input  logic                 rx_tready,
  input  logic                 rx_tlast,
`ifdef MAPLE_SEQ_IRQ_EN
  input  logic                 irq_on_ok,
  input  logic                 irq_clr,
`endif
  output logic                 tx_enable,
  output logic                 rx_enable,
  output logic                 bus_drive,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           status,
  output logic                 irq
);

  maple_state_e         state;
  logic [TIMEOUT_W-1:0] timeout_cfg;
  logic [TURN_W-1:0]    turn_cfg;
  logic                 timer_run;
  logic                 timer_clr;
  logic                 timer_hit;
  logic [TIMEOUT_W-1:0] timer_limit;

`ifdef MAPLE_SEQ_IRQ_EN
  logic irq_q;
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // TURN runs straight into RX_WAIT, so the timer is also restarted on its last cycle.
  always_comb begin
    timer_run   = (state == ST_TX_ARM) || (state == ST_TURN) || (state == ST_RX_WAIT);
    timer_clr   = !timer_run || ((state == ST_TURN) && timer_hit);
    timer_limit = (state == ST_TURN) ? TIMEOUT_W'(turn_cfg) : timeout_cfg;
  end

  maple_seq_timer #(
    .W(TIMEOUT_W)
  ) u_timer (
    .clk   (aclk),
    .rst_n (aresetn),
    .clr   (timer_clr),
    .limit (timer_limit),
    .hit   (timer_hit)
  );

  task automatic finish(input logic [2:0] code);
    state     <= ST_DONE;
    status    <= code;
    done      <= 1'b1;
    busy      <= 1'b0;
    tx_enable <= 1'b0;
    rx_enable <= 1'b0;
    bus_drive <= 1'b0;
`ifdef MAPLE_SEQ_IRQ_EN
    if ((code != MAPLE_ST_OK) || irq_on_ok) begin
      irq_q <= 1'b1;
    end
`endif
  endtask

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      status      <= MAPLE_ST_OK;
      tx_enable   <= 1'b0;
      rx_enable   <= 1'b0;
      bus_drive   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_cfg <= '0;
      turn_cfg    <= '0;
`ifdef MAPLE_SEQ_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MAPLE_SEQ_IRQ_EN
      if (irq_clr) begin
        irq_q <= 1'b0;
      end
`endif
      // busy is high exactly in the abortable states (TX_ARM .. RX_ACTIVE).
      if (busy && abort) begin
        finish(MAPLE_ST_ABORT);
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              timeout_cfg <= cfg_timeout;
              turn_cfg    <= cfg_turnaround;
              if (tx_pkt_avail) begin
                state     <= ST_TX_ARM;
                tx_enable <= 1'b1;
                bus_drive <= 1'b1;
                busy      <= 1'b1;
              end else begin
                finish(MAPLE_ST_NO_PKT);
              end
            end
          end
          ST_TX_ARM: begin
            if (transmitting) begin
              state <= ST_TX_ACTIVE;
            end else if (timer_hit) begin
              finish(MAPLE_ST_TX_TIMEOUT);
            end
          end
          ST_TX_ACTIVE: begin
            if (!transmitting) begin
              tx_enable <= 1'b0;
              bus_drive <= 1'b0;
              if (turn_cfg == '0) begin
                state     <= ST_RX_WAIT;
                rx_enable <= 1'b1;
              end else begin
                state <= ST_TURN;
              end
            end
          end
          ST_TURN: begin
            if (timer_hit) begin
              state     <= ST_RX_WAIT;
              rx_enable <= 1'b1;
            end
          end
          ST_RX_WAIT: begin
            if (receiving) begin
              state <= ST_RX_ACTIVE;
            end else if (timer_hit) begin
              finish(MAPLE_ST_RX_TIMEOUT);
            end
          end
          ST_RX_ACTIVE: begin
            // An accepted tlast beat outranks receiving dropping in the same cycle.
            if (rx_tvalid && rx_tready && rx_tlast) begin
              finish(MAPLE_ST_OK);
            end else if (!receiving) begin
              finish(MAPLE_ST_RX_ERR);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_maple_bus_sequencer.sv
// Self-checking bench for maple_bus_sequencer: directed table, randomized
// transactions against a timeline model, and hand-written corner sequences.
module tb_maple_bus_sequencer;

  localparam int TW  = 24;
  localparam int NW  = 8;
  localparam int BIG = 1 << 28;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          start;
  logic          abort;
  logic [TW-1:0] cfg_timeout;
  logic [NW-1:0] cfg_turnaround;
  logic          tx_pkt_avail;
  logic          transmitting;
  logic          receiving;
  logic          rx_tvalid;
  logic          rx_tready;
  logic          rx_tlast;
  logic          tx_enable;
  logic          rx_enable;
  logic          bus_drive;
  logic          busy;
  logic          done;
  logic [2:0]    status;
  logic          irq;
`ifdef MAPLE_SEQ_IRQ_EN
  logic          irq_on_ok;
  logic          irq_clr;
  bit            model_irq = 1'b0;
  bit            last_clr  = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int prev_st = 0;
  int txn_id = 0;

  typedef struct {
    bit avail;
    int t;
    int a;
    int s;
    int l;
    int r;
    int m;
    bit last;
    int b;
    int ab;
    int exp_d;
    int exp_st;
  } vec_t;

  vec_t tbl[12];

  always #5 aclk = ~aclk;

  maple_bus_sequencer dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .start          (start),
    .abort          (abort),
    .cfg_timeout    (cfg_timeout),
    .cfg_turnaround (cfg_turnaround),
    .tx_pkt_avail   (tx_pkt_avail),
    .transmitting   (transmitting),
    .receiving      (receiving),
    .rx_tvalid      (rx_tvalid),
    .rx_tready      (rx_tready),
    .rx_tlast       (rx_tlast),
`ifdef MAPLE_SEQ_IRQ_EN
    .irq_on_ok      (irq_on_ok),
    .irq_clr        (irq_clr),
`endif
    .tx_enable      (tx_enable),
    .rx_enable      (rx_enable),
    .bus_drive      (bus_drive),
    .busy           (busy),
    .done           (done),
    .status         (status),
    .irq            (irq)
  );

  initial begin
    #1500000;
    $display("FAIL watchdog simulation time exhausted");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] pack_out();
    return {tx_enable, rx_enable, bus_drive, busy, done, status, irq};
  endfunction

  function automatic logic [8:0] idle_vec();
    logic e_irq;
    e_irq = 1'b0;
`ifdef MAPLE_SEQ_IRQ_EN
    e_irq = model_irq;
`endif
    return {5'b00000, 3'(prev_st), e_irq};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {tx,rx,drv,busy,done,st,irq}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_model();
    @(posedge aclk);
    #1;
`ifdef MAPLE_SEQ_IRQ_EN
    if (last_clr) model_irq = 1'b0;
    last_clr = irq_clr;
`endif
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; transmitting = 0; receiving = 0;
    rx_tvalid = 0; rx_tready = 0; rx_tlast = 0; tx_pkt_avail = 0;
`ifdef MAPLE_SEQ_IRQ_EN
    irq_clr = 0;
`endif
  endtask

  // Timeline model: cycle 0 carries the start pulse; cycle c shows the outputs
  // produced by the edge at the end of cycle c-1.
  task automatic run_txn(input vec_t v, output int obs_d, output int obs_st);
    int d, st, tx_end, w;
    bit e_tx, e_rx, e_busy, e_irq, beat;
    int e_st;
    logic [2:0] x;
    if (!v.avail) begin
      d = 1; st = 5; tx_end = 0; w = BIG;
    end else if (v.t != 0 && v.s > v.t) begin
      d = v.t + 1; st = 1; tx_end = v.t; w = BIG;
    end else begin
      tx_end = v.s + v.l;
      w = tx_end + 1 + v.a;
      if (v.t != 0 && v.r >= v.t) begin
        d = w + v.t; st = 2;
      end else if (v.last && v.b <= v.m) begin
        d = w + v.r + v.b + 1; st = 0;
      end else begin
        d = w + v.r + v.m + 1; st = 3;
      end
    end
    if (v.ab >= 1 && v.ab <= d - 1) begin
      d = v.ab + 1; st = 4;
    end
`ifdef MAPLE_SEQ_IRQ_EN
    irq_on_ok = 1'($urandom);
`endif
    obs_d = -1;
    obs_st = -1;
    for (int c = 0; c <= d + 1; c++) begin
      e_tx   = (c >= 1) && (c <= tx_end) && (c <= d - 1);
      e_rx   = (c >= w) && (c <= d - 1);
      e_busy = (c >= 1) && (c <= d - 1);
      e_st   = (c >= d) ? st : prev_st;
      e_irq  = 1'b0;
`ifdef MAPLE_SEQ_IRQ_EN
      if (c == d && (st != 0 || irq_on_ok)) model_irq = 1'b1;
      else if (last_clr) model_irq = 1'b0;
      e_irq = model_irq;
`endif
      check($sformatf("txn%0d_cycle%0d", txn_id, c), pack_out(),
            {e_tx, e_rx, e_tx, e_busy, (c == d), 3'(e_st), e_irq});
      if (done && obs_d < 0) begin
        obs_d = c;
        obs_st = int'(status);
      end
      start          = (c == 0) || (c >= 1 && c <= d - 1 && $urandom_range(15) == 0);
      abort          = (v.ab != 0) && (c == v.ab) && (c < d);
      cfg_timeout    = (c == 0) ? TW'(v.t) : TW'($urandom);
      cfg_turnaround = (c == 0) ? NW'(v.a) : NW'($urandom);
      tx_pkt_avail   = (c == 0) ? v.avail : 1'($urandom);
      transmitting   = v.avail && (c >= v.s) && (c < v.s + v.l) && (c < d);
      receiving      = (c >= w + v.r) && (c < w + v.r + v.m) && (c < d);
      beat           = v.last && (c == w + v.r + v.b) && (c < d);
      if (beat) begin
        x = 3'b111;
      end else begin
        x = 3'($urandom);
        if (x == 3'b111) x = 3'b011;
      end
      {rx_tvalid, rx_tready, rx_tlast} = x;
`ifdef MAPLE_SEQ_IRQ_EN
      irq_clr  = ($urandom_range(7) == 0);
      last_clr = irq_clr;
`endif
      @(posedge aclk);
      #1;
    end
    prev_st = st;
    txn_id++;
  endtask

  initial begin
    int od, ost, done_seen;
    vec_t v;
    aresetn = 1'b1;
    cfg_timeout = '0;
    cfg_turnaround = '0;
    idle_inputs();
`ifdef MAPLE_SEQ_IRQ_EN
    irq_on_ok = 1'b0;
`endif
    #2 aresetn = 1'b0;
    #1 check("reset_async", pack_out(), 9'd0);
    repeat (2) @(posedge aclk);
    #1 check("reset_state", pack_out(), 9'd0);
    aresetn = 1'b1;
    step_model();

    //        avail  t   a  s  l   r    m last b  ab  exp_d st
    tbl[0]  = '{1, 100, 4, 1, 20, 10,   40, 1, 30, 0,  67, 0};
    tbl[1]  = '{1,  50, 2, 3,  5, 1000,  5, 0,  1, 0,  61, 2};
    tbl[2]  = '{0,  10, 1, 1,  1, 0,     1, 0,  1, 0,   1, 5};
    tbl[3]  = '{1, 100, 3, 2,  4, 2,    20, 1, 15, 16, 17, 4};
    tbl[4]  = '{1,   0, 1, 1,  3, 5,     6, 0,  1, 0,  18, 3};
    tbl[5]  = '{1,  20, 0, 2,  3, 0,     4, 1,  4, 0,  11, 0};
    tbl[6]  = '{1,   5, 2, 9,  3, 0,     3, 1,  1, 0,   6, 1};
    tbl[7]  = '{1,   5, 2, 5,  2, 1,     3, 1,  2, 0,  14, 0};
    tbl[8]  = '{1,   8, 1, 1,  2, 7,     3, 1,  1, 0,  14, 0};
    tbl[9]  = '{1,   8, 1, 1,  2, 8,     3, 1,  1, 0,  13, 2};
    tbl[10] = '{1,   5, 2, 9,  3, 0,     3, 1,  1, 5,   6, 4};
    tbl[11] = '{1,  30, 1, 1,  2, 0,     3, 1,  5, 0,   9, 3};
    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i], od, ost);
      check_int($sformatf("tbl%0d_done_cycle", i), od, tbl[i].exp_d);
      check_int($sformatf("tbl%0d_status", i), ost, tbl[i].exp_st);
    end

    for (int i = 0; i < 120; i++) begin
      v.avail  = ($urandom_range(7) != 0);
      v.t      = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(30, 1));
      v.a      = int'($urandom_range(5));
      v.s      = int'($urandom_range(35, 1));
      v.l      = int'($urandom_range(15, 1));
      v.r      = int'($urandom_range(34));
      v.m      = int'($urandom_range(20, 1));
      v.last   = ($urandom_range(3) != 0);
      v.b      = int'($urandom_range(v.m + 2, 1));
      v.ab     = ($urandom_range(4) == 0) ? int'($urandom_range(80, 1)) : 0;
      v.exp_d  = -1;
      v.exp_st = -1;
      run_txn(v, od, ost);
    end

    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      abort = 1'b1;
      step_model();
      check($sformatf("abort_idle_%0d", i), pack_out(), idle_vec());
    end
    abort = 1'b0;

    start = 1'b1; tx_pkt_avail = 1'b1; cfg_timeout = '0; cfg_turnaround = 8'd2;
    step_model();
    start = 1'b0; transmitting = 1'b1;
    repeat (3) step_model();
    transmitting = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10000; i++) begin
      step_model();
      if (done) done_seen = 1;
    end
    check_int("no_timeout_busy_rx_nodone", {busy, rx_enable, 1'(done_seen)}, 6);
    abort = 1'b1;
    step_model();
    abort = 1'b0;
    prev_st = 4;
`ifdef MAPLE_SEQ_IRQ_EN
    model_irq = 1'b1;
`endif
    check("abort_rx_wait_done", pack_out(), idle_vec() | 9'b000010000);
    step_model();
    check("abort_rx_wait_idle", pack_out(), idle_vec());

    start = 1'b1; tx_pkt_avail = 1'b1; cfg_timeout = 24'd100; cfg_turnaround = 8'd1;
    step_model();
    start = 1'b0; transmitting = 1'b1;
    step_model();
    step_model();
    check_int("pre_reset_tx_drive_busy", {tx_enable, bus_drive, busy}, 7);
`ifdef MAPLE_SEQ_IRQ_EN
    check_int("pre_reset_irq", int'(irq), int'(model_irq));
`endif
    #3 aresetn = 1'b0;
    #1 check("async_reset_mid_tx", pack_out(), 9'd0);
    #1 aresetn = 1'b1;
    transmitting = 1'b0;
    prev_st = 0;
`ifdef MAPLE_SEQ_IRQ_EN
    model_irq = 1'b0;
`endif
    step_model();
    check("after_reset_idle", pack_out(), idle_vec());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maple_bus_sequencer.md
Name: maple_bus_sequencer

Overview:
- Transaction controller for one Maple Bus host exchange: enables the transmitter for one queued packet, owns pin direction, performs line turnaround, opens a bounded receive window, and reports completion status.
- Sits beside the AXI-Lite control block. It replaces the direct FIFO-valid enables of the transmitter and receiver, and the static direction gating, with a sequenced command/response flow.

Parameters:
TIMEOUT_W, 24, width of response/start timeout counter and cfg_timeout
TURN_W, 8, width of turnaround counter and cfg_turnaround

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
start  in  1  single-cycle command pulse from control registers
abort  in  1  single-cycle abort pulse
cfg_timeout  in  TIMEOUT_W  cycle budget for TX start and RX response; 0 = wait forever
cfg_turnaround  in  TURN_W  idle cycles between end of TX and RX enable
tx_pkt_avail  in  1  TX FIFO holds at least one tlast-terminated packet
transmitting  in  1  transmitter TRANSMITTING
receiving  in  1  receiver RECEIVING
rx_tvalid  in  1  receiver-to-FIFO stream valid
rx_tready  in  1  receiver-to-FIFO stream ready
rx_tlast  in  1  receiver-to-FIFO stream last
tx_enable  out  1  transmitter ENABLE
rx_enable  out  1  receiver ENABLE
bus_drive  out  1  1 = pads driven by transmitter, 0 = released (Z)
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
status  out  3  result, valid from done onward: 0 OK, 1 TX_TIMEOUT, 2 RX_TIMEOUT, 3 RX_ERR, 4 ABORT, 5 NO_PKT
irq  out  1  see Optional Feature

Behaviour:
- Reset: all outputs 0, status 0, state IDLE, counters 0.
- All outputs are registered. State changes take effect on the cycle after the triggering input.
- States: IDLE, TX_ARM, TX_ACTIVE, TURN, RX_WAIT, RX_ACTIVE, DONE.
- IDLE:
  - start & tx_pkt_avail -> TX_ARM.
  - start & !tx_pkt_avail -> DONE, status NO_PKT.
- TX_ARM: tx_enable=1, bus_drive=1, busy=1, timer counts from 0.
  - transmitting=1 -> TX_ACTIVE.
  - cfg_timeout!=0 and timer==cfg_timeout-1 with transmitting still 0 -> DONE, status TX_TIMEOUT.
- TX_ACTIVE: tx_enable=1, bus_drive=1.
  - transmitting falls -> TURN; tx_enable and bus_drive drop in the same transition.
- TURN: all enables 0, bus released, stays exactly cfg_turnaround cycles.
  - cfg_turnaround=0 -> RX_WAIT directly from TX_ACTIVE.
- RX_WAIT: rx_enable=1, timer restarted at 0.
  - receiving=1 -> RX_ACTIVE.
  - Otherwise, after exactly cfg_timeout cycles in RX_WAIT (cfg_timeout!=0) -> DONE, status RX_TIMEOUT.
  - If receiving and the timeout land in the same cycle, receiving wins.
- RX_ACTIVE: rx_enable=1.
  - rx_tvalid & rx_tready & rx_tlast -> DONE, status OK.
  - receiving falls without a tlast beat accepted -> DONE, status RX_ERR.
  - A tlast beat and the fall of receiving in the same cycle -> OK.
- DONE: one cycle, done=1, busy=0 -> IDLE. status holds until the next DONE.
- abort in any non-IDLE state wins over every other transition: -> DONE, status ABORT; enables and bus_drive are 0 on the next cycle. abort in IDLE is ignored.
- start while busy is ignored and not queued.
- The timer does not count past cfg_timeout.
- cfg_* are sampled on start; later changes do not affect the transaction in flight.
- Asynchronous reset mid-transaction: immediate return to IDLE; pads are released at once (bus_drive=0).

Optional Feature:
- Macro MAPLE_SEQ_IRQ_EN.
- Defined:
  - irq is a sticky level, set on the done cycle for any status other than OK, or for OK as well when irq_on_ok=1.
  - Extra ports: irq_on_ok in 1, irq_clr in 1.
  - irq_clr clears irq; a set and a clear in the same cycle resolve to set.
- Undefined: irq tied to 0; extra ports absent.

Decomposition:
- Package maple_bus_pkg holds:
  - state enum;
  - status codes (MAPLE_ST_OK … MAPLE_ST_NO_PKT);
  - default TIMEOUT_W/TURN_W constants.
- One sub-module, maple_seq_timer: loadable up-counter with terminal-compare, zero-means-disabled, and saturation. It is shared by the TX_ARM, TURN and RX_WAIT phases.

Test Plan:
- Nominal exchange:
  - Stimulus: tx_pkt_avail=1, cfg_turnaround=4, cfg_timeout=100, start; transmitting high 20 cycles; receiving rises 10 cycles after TURN; tlast beat 30 cycles later.
  - Response: bus_drive high exactly during TX_ARM/TX_ACTIVE, 4 idle cycles, rx_enable until tlast, done pulse, status=0.
- RX timeout:
  - Stimulus: cfg_timeout=50, receiving never rises.
  - Response: exactly 50 RX_WAIT cycles, then done, status=2, rx_enable=0 next cycle.
- No packet / busy start:
  - Stimulus: start with tx_pkt_avail=0.
  - Response: done 1 cycle later, status=5, tx_enable never asserted.
  - Stimulus: second start during TX_ACTIVE.
  - Response: ignored.
- Abort mid-receive:
  - Stimulus: abort in RX_ACTIVE.
  - Response: next cycle done=1, status=4, all enables 0.
  - Stimulus: abort in IDLE.
  - Response: no effect.
- Errors and boundaries:
  - Stimulus: receiving falls with no tlast.
  - Response: status=3.
  - Stimulus: cfg_turnaround=0.
  - Response: RX_WAIT the cycle after transmitting falls.
  - Stimulus: cfg_timeout=0 with a 10000-cycle silent line.
  - Response: still busy.
- IRQ (MAPLE_SEQ_IRQ_EN):
  - Stimulus: RX timeout.
  - Response: irq=1 until irq_clr.
  - Stimulus: OK completion with irq_on_ok=0.
  - Response: irq stays 0.
  - Stimulus: irq_clr coincident with a set.
  - Response: irq=1.
  - Stimulus: aresetn low mid-TX.
  - Response: bus_drive=0 and irq=0 immediately.
